// File: rtl/regfile_dump_reader_pkg.sv
// Shared widths and FSM state encoding for the register-file dump reader.
package regfile_dump_reader_pkg;
   localparam int ADDR_W = 5;   // register index width, matches the register file
   localparam int DATA_W = 32;  // register word width, matches the register file

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// Control, register-file read port and output stream of the dump reader.
// The slave side is the reader itself. The master side is the requester/consumer,
// which also returns ReadData from the register file.
interface regfile_dump_reader_if;
   import regfile_dump_reader_pkg::*;

   logic              Start;
   logic              Abort;
   logic [ADDR_W-1:0] ReadReg;
   logic [DATA_W-1:0] ReadData;
   logic              OutValid;
   logic              OutReady;
   logic [ADDR_W-1:0] OutIndex;
   logic [DATA_W-1:0] OutData;
   logic              Busy;
   logic              Done;

   modport slave (
      input  Start, Abort, ReadData, OutReady,
      output ReadReg, OutValid, OutIndex, OutData, Busy, Done
   );

   modport master (
      output Start, Abort, ReadData, OutReady,
      input  ReadReg, OutValid, OutIndex, OutData, Busy, Done
   );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks register indices FIRST_REG..NUM_REGS-1 through one register-file read
// port. Each returned word is presented as an {index, data} valid/ready stream.
// There is no write interlock: each word is the register value at its own read edge.
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int NUM_REGS     = 32,
   parameter int READ_LATENCY = 1,
   parameter int FIRST_REG    = 0
) (
   input  logic                   Clock,
   input  logic                   Reset_L,
   regfile_dump_reader_if.slave   bus
);
   localparam int                CNT_W     = $clog2(READ_LATENCY + 1) + 1;
   localparam logic [CNT_W-1:0]  LAT_LAST  = CNT_W'(READ_LATENCY);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_read_reg;
   logic              r_out_valid;
   logic [ADDR_W-1:0] r_out_index;
   logic [DATA_W-1:0] r_out_data;
   logic              r_busy;
   logic              r_done;

   assign bus.ReadReg  = r_read_reg;
   assign bus.OutValid = r_out_valid;
   assign bus.OutIndex = r_out_index;
   assign bus.OutData  = r_out_data;
   assign bus.Busy     = r_busy;
   assign bus.Done     = r_done;

   // Dump FSM with registered outputs. Abort outranks everything except reset.
   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_read_reg  <= '0;
         r_out_valid <= 1'b0;
         r_out_index <= '0;
         r_out_data  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else if (bus.Abort && r_state != ST_IDLE) begin
         // A word waiting in HOLD is dropped, even if OutReady is high this cycle.
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_read_reg  <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.Start) begin
                  r_state    <= ST_ISSUE;
                  r_addr     <= FIRST_IDX;
                  r_read_reg <= FIRST_IDX;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
               end
            end
            ST_ISSUE: begin
               // ReadReg has been stable for READ_LATENCY edges. ReadData is valid now.
               if (r_cnt == LAT_LAST) begin
                  r_out_data  <= bus.ReadData;
                  r_out_index <= r_addr;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_HOLD;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (bus.OutReady) begin
                  r_out_valid <= 1'b0;
                  // Compare before incrementing, so the index never wraps.
                  if (r_addr == LAST_IDX) begin
                     r_state    <= ST_DONE;
                     r_read_reg <= '0;
                     r_done     <= 1'b1;
                  end else begin
                     r_state    <= ST_ISSUE;
                     r_addr     <= r_addr + ADDR_W'(1);
                     r_read_reg <= r_addr + ADDR_W'(1);
                     r_cnt      <= '0;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for the dump reader. A behavioural 32x32 register file has two
// posedge read ports: port 1 feeds a FIRST_REG=0 reader and port 2 feeds a FIRST_REG=1 reader.
module tb_regfile_dump_reader;
   import regfile_dump_reader_pkg::*;

   typedef logic [ADDR_W+DATA_W-1:0] word_t;

   logic Clock   = 1'b0;
   logic Reset_L = 1'b0;
   always #5 Clock = ~Clock;

   regfile_dump_reader_if bus0 ();
   regfile_dump_reader_if bus1 ();

   regfile_dump_reader #(.NUM_REGS(32), .READ_LATENCY(1), .FIRST_REG(0)) u_dut0 (
      .Clock(Clock), .Reset_L(Reset_L), .bus(bus0.slave));
   regfile_dump_reader #(.NUM_REGS(32), .READ_LATENCY(1), .FIRST_REG(1)) u_dut1 (
      .Clock(Clock), .Reset_L(Reset_L), .bus(bus1.slave));

   // Register file model: async clear, one write port, two posedge read ports.
   logic              rf_we;
   logic [ADDR_W-1:0] rf_wa;
   logic [DATA_W-1:0] rf_wd;
   logic [DATA_W-1:0] mem [32];
   always @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
         bus0.ReadData <= '0;
         bus1.ReadData <= '0;
      end else begin
         if (rf_we) mem[rf_wa] <= rf_wd;
         bus0.ReadData <= mem[bus0.ReadReg];
         bus1.ReadData <= mem[bus1.ReadReg];
      end
   end

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   // Stream monitors: accepted words, Done pulses, timing and HOLD stability.
   word_t q0[$];
   word_t q1[$];
   int    done0 = 0, done1 = 0, start0_cyc = 0, done0_cyc = 0, fv0_cyc = 0, stab_err = 0;
   bit    fv_seen = 1'b0, hold_pend = 1'b0;
   word_t hold_val = '0;
   always @(posedge Clock) begin
      if (Reset_L) begin
         if (bus0.Start && !bus0.Busy) begin start0_cyc <= cyc; fv_seen <= 1'b0; end
         if (bus0.OutValid && !fv_seen) begin fv_seen <= 1'b1; fv0_cyc <= cyc; end
         if (bus0.Done) begin done0 <= done0 + 1; done0_cyc <= cyc; end
         if (hold_pend && bus0.OutValid && {bus0.OutIndex, bus0.OutData} != hold_val)
            stab_err <= stab_err + 1;
         hold_pend <= bus0.OutValid && !bus0.OutReady && !bus0.Abort;
         hold_val  <= {bus0.OutIndex, bus0.OutData};
         if (bus0.OutValid && bus0.OutReady && !bus0.Abort) q0.push_back({bus0.OutIndex, bus0.OutData});
         if (bus1.Done) done1 <= done1 + 1;
         if (bus1.OutValid && bus1.OutReady && !bus1.Abort) q1.push_back({bus1.OutIndex, bus1.OutData});
      end else begin
         hold_pend <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic chk_words(input string tag, input word_t q[$], input int first, input int n,
                            input bit zero);
      for (int i = 0; i < n; i++) begin
         word_t got, exp;
         got = (i < q.size()) ? q[i] : '1;
         exp = {ADDR_W'(first + i), zero ? DATA_W'(0) : DATA_W'(32'h1000_0000 + first + i)};
         chk(tag, {27'd0, got}, {27'd0, exp});
      end
   endtask

   task automatic preload();
      for (int i = 0; i < 32; i++) begin
         @(negedge Clock);
         rf_we = 1'b1; rf_wa = ADDR_W'(i); rf_wd = 32'h1000_0000 + i;
      end
      @(negedge Clock);
      rf_we = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_readreg"}, 64'(bus0.ReadReg), 0);
      chk({tag, "_valid"},   64'(bus0.OutValid), 0);
      chk({tag, "_index"},   64'(bus0.OutIndex), 0);
      chk({tag, "_data"},    64'(bus0.OutData), 0);
      chk({tag, "_busy"},    64'(bus0.Busy), 0);
      chk({tag, "_done"},    64'(bus0.Done), 0);
   endtask

   // Run one dut0 dump. mode 1 throttles OutReady to 1-of-3 cycles.
   // ev 1: Abort while HOLD at ev_idx. ev 2: Reset while ISSUE at ev_idx.
   // ev 3: extra Start while busy at ev_idx.
   task automatic run0(input int mode, input int ev, input int ev_idx);
      int base, k;
      bit fired, stop;
      base = done0; k = 0; fired = 1'b0; stop = 1'b0;
      @(negedge Clock);
      bus0.Start = 1'b1; bus0.OutReady = 1'b1;
      forever begin
         @(negedge Clock);
         bus0.Start = 1'b0; bus0.Abort = 1'b0;
         if (done0 != base || stop) break;
         if (k >= 600) begin chk("run0_timeout", 64'(k), 0); break; end
         bus0.OutReady = (mode == 0) || (k % 3 == 0);
         if (!fired && ev == 1 && bus0.OutValid && bus0.OutIndex == ADDR_W'(ev_idx)) begin
            bus0.Abort = 1'b1; bus0.OutReady = 1'b1; fired = 1'b1; stop = 1'b1;
         end
         if (!fired && ev == 2 && bus0.Busy && !bus0.OutValid && bus0.ReadReg == ADDR_W'(ev_idx)) begin
            Reset_L = 1'b0; fired = 1'b1; break;
         end
         if (!fired && ev == 3 && bus0.Busy && bus0.ReadReg == ADDR_W'(ev_idx)) begin
            bus0.Start = 1'b1; fired = 1'b1;
         end
         k++;
      end
   endtask

   initial begin
      int b;
      bus0.Start = 1'b0; bus0.Abort = 1'b0; bus0.OutReady = 1'b0;
      bus1.Start = 1'b0; bus1.Abort = 1'b0; bus1.OutReady = 1'b0;
      rf_we = 1'b0; rf_wa = '0; rf_wd = '0;

      // Reset state
      repeat (2) @(negedge Clock);
      chk_outputs_zero("reset");
      Reset_L = 1'b1;
      preload();

      // Full dump with OutReady held high
      q0.delete(); b = done0;
      run0(0, 0, 0);
      chk("t1_count", 64'(q0.size()), 32);
      chk_words("t1_word", q0, 0, 32, 1'b0);
      chk("t1_done_cnt", 64'(done0 - b), 1);
      chk("t1_done_lat", 64'(done0_cyc - start0_cyc), 97);
      chk("t1_first_valid", 64'(fv0_cyc - start0_cyc), 3);
      chk("t1_busy_after", 64'(bus0.Busy), 0);

      // Throttled consumer
      q0.delete(); b = done0; stab_err = 0;
      run0(1, 0, 0);
      chk("t2_count", 64'(q0.size()), 32);
      chk_words("t2_word", q0, 0, 32, 1'b0);
      chk("t2_done_cnt", 64'(done0 - b), 1);
      chk("t2_stable", 64'(stab_err), 0);

      // FIRST_REG=1 instance on the second read port
      q1.delete(); b = done1;
      @(negedge Clock); bus1.Start = 1'b1; bus1.OutReady = 1'b1;
      @(negedge Clock); bus1.Start = 1'b0;
      for (int k = 0; k < 600 && done1 == b; k++) @(negedge Clock);
      chk("t3_count", 64'(q1.size()), 31);
      chk_words("t3_word", q1, 1, 31, 1'b0);
      chk("t3_done_cnt", 64'(done1 - b), 1);

      // Abort while HOLD on index 5 with OutReady high
      q0.delete(); b = done0;
      run0(0, 1, 5);
      chk("t4_busy", 64'(bus0.Busy), 0);
      chk("t4_valid", 64'(bus0.OutValid), 0);
      chk("t4_count", 64'(q0.size()), 5);
      chk_words("t4_word", q0, 0, 5, 1'b0);
      repeat (4) @(negedge Clock);
      chk("t4_no_done", 64'(done0 - b), 0);
      q0.delete(); b = done0;
      run0(0, 0, 0);
      chk("t4_restart_count", 64'(q0.size()), 32);
      chk_words("t4_restart_word", q0, 0, 1, 1'b0);
      chk("t4_restart_done", 64'(done0 - b), 1);

      // Reset while ISSUE at index 12, then dump the cleared register file
      q0.delete(); b = done0;
      run0(0, 2, 12);
      #1;
      chk_outputs_zero("t5_reset");
      chk("t5_no_done", 64'(done0 - b), 0);
      repeat (2) @(negedge Clock);
      Reset_L = 1'b1;
      q0.delete(); b = done0;
      run0(0, 0, 0);
      chk("t5_count", 64'(q0.size()), 32);
      chk_words("t5_word", q0, 0, 32, 1'b1);
      chk("t5_done_cnt", 64'(done0 - b), 1);

      // Start pulsed while busy at index 7 is ignored
      preload();
      q0.delete(); b = done0;
      run0(0, 3, 7);
      chk("t6_count", 64'(q0.size()), 32);
      chk_words("t6_word", q0, 0, 32, 1'b0);
      chk("t6_done_cnt", 64'(done0 - b), 1);
      chk("t6_done_lat", 64'(done0_cyc - start0_cyc), 97);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
